// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and system reset sequencer with optional clock-enable divider.
// Ports: clk_sys, rst_n (async, active low), pll_locked (async), soft_rst;
//        sys_rst_n, ready, lost_cnt[7:0], ce.  Macro PLL_RESET_SEQ_CE_EN builds the ce divider.
module pll_reset_seq #(
    parameter int FILT_CYCLES = 16,
    parameter int HOLD_CYCLES = 64,
    parameter int CE_DIV      = 3
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] lost_cnt,
    output logic       ce
);

    if (FILT_CYCLES < 1 || FILT_CYCLES > 65535) begin : g_bad_filt
        $error("FILT_CYCLES out of range");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("HOLD_CYCLES out of range");
    end
    if (CE_DIV < 1 || CE_DIV > 256) begin : g_bad_div
        $error("CE_DIV out of range");
    end

    typedef enum logic [2:0] {
        S_WAIT,
        S_FILT,
        S_HOLD,
        S_RUN,
        S_LOST
    } state_t;

    localparam logic [15:0] FILT_LAST = 16'(FILT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      nstate;
    logic [15:0] cnt;
    logic [15:0] ncnt;
    logic        sync1;
    logic        locked_s;

    // Lock loss is checked first in every state so it beats soft_rst.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        unique case (state)
            S_WAIT: begin
                if (locked_s) begin
                    nstate = S_FILT;
                    ncnt   = '0;
                end
            end
            S_FILT: begin
                if (!locked_s) begin
                    nstate = S_WAIT;
                    ncnt   = '0;
                end else if (cnt == FILT_LAST) begin
                    nstate = S_HOLD;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 16'd1;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    nstate = S_LOST;
                    ncnt   = '0;
                end else if (soft_rst) begin
                    ncnt = '0;
                end else if (cnt == HOLD_LAST) begin
                    nstate = S_RUN;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 16'd1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    nstate = S_LOST;
                end else if (soft_rst) begin
                    nstate = S_HOLD;
                    ncnt   = '0;
                end
            end
            S_LOST: begin
                nstate = S_WAIT;
                ncnt   = '0;
            end
            default: begin
                nstate = S_WAIT;
                ncnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            locked_s  <= 1'b0;
            state     <= S_WAIT;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            lost_cnt  <= '0;
        end else begin
            sync1     <= pll_locked;
            locked_s  <= sync1;
            state     <= nstate;
            cnt       <= ncnt;
            // Outputs follow next state so they change on the same edge as state.
            sys_rst_n <= (nstate == S_RUN);
            ready     <= (nstate == S_RUN);
            if (state == S_LOST && lost_cnt != 8'hFF) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

`ifdef PLL_RESET_SEQ_CE_EN
    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] CE_LAST = CW'(CE_DIV - 1);

    logic [CW-1:0] ce_cnt;
    logic [CW-1:0] nce_cnt;

    // Counter restarts from 0 on the first RUN cycle and is parked at 0 elsewhere.
    always_comb begin
        nce_cnt = '0;
        if (nstate == S_RUN && state == S_RUN && ce_cnt != CE_LAST) begin
            nce_cnt = ce_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt <= '0;
            ce     <= 1'b0;
        end else begin
            ce_cnt <= nce_cnt;
            ce     <= (nstate == S_RUN) && (nce_cnt == CE_LAST);
        end
    end
`else
    assign ce = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq against an event-level reference model.
// Directed scenarios followed by a randomized lock/soft-reset run.
module tb_pll_reset_seq;

    localparam int F = 16;
    localparam int H = 64;
    localparam int D = 3;

    logic       clk_sys    = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst   = 1'b0;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] lost_cnt;
    logic       ce;

    pll_reset_seq #(
        .FILT_CYCLES(F),
        .HOLD_CYCLES(H),
        .CE_DIV     (D)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .soft_rst  (soft_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .lost_cnt  (lost_cnt),
        .ce        (ce)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    // Reference model: lock pipe, edges remaining to RUN, run age.
    bit m_s1, m_s2;
    bit m_active, m_run, m_lostpend;
    int m_t, m_lost, m_runage, edge_n;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0;
        m_active = 0; m_run = 0; m_lostpend = 0;
        m_t = 0; m_lost = 0; m_runage = 0;
    endfunction

    function automatic void model_edge(input bit lk, input bit sr);
        bit ls;
        bit was_run;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        was_run = m_run;
        edge_n++;
        if (m_lostpend) begin
            m_lostpend = 0;
            if (m_lost < 255) m_lost++;
        end else if (m_run) begin
            if (!ls) begin
                m_run = 0;
                m_lostpend = 1;
            end else if (sr) begin
                m_run = 0;
                m_active = 1;
                m_t = H;
            end
        end else if (m_active) begin
            if (!ls) begin
                m_active = 0;
                if (m_t <= H) m_lostpend = 1;
            end else begin
                if (sr && m_t <= H) m_t = H;
                else m_t--;
                if (m_t == 0) begin
                    m_active = 0;
                    m_run = 1;
                end
            end
        end else if (ls) begin
            m_active = 1;
            m_t = F + H;
        end
        if (m_run) m_runage = was_run ? m_runage + 1 : 0;
    endfunction

    function automatic bit exp_ce();
`ifdef PLL_RESET_SEQ_CE_EN
        return m_run && ((m_runage % D) == D - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("sys_rst_n", 32'(sys_rst_n), 32'(m_run));
        check("ready", 32'(ready), 32'(m_run));
        check("lost_cnt", 32'(lost_cnt), 32'(m_lost));
        check("ce", 32'(ce), 32'(exp_ce()));
    endtask

    task automatic step(input bit lk, input bit sr);
        pll_locked = lk;
        soft_rst   = sr;
        @(posedge clk_sys);
        model_edge(lk, sr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk_sys);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    int k;
    int lowc;
    int base;
    bit seen;

    initial begin
        model_reset();
        edge_n = 0;

        // Power-on reset, then a clean lock.
        do_reset();
        step(1, 0);
        k = edge_n;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (sys_rst_n === 1'b1) seen = 1;
            else step(1, 0);
        end
        check("lock_to_run", 32'(edge_n - k), 32'd82);
        for (int i = 0; i < 8; i++) step(1, 0);

        // One-cycle glitch in the filter window restarts the filter.
        do_reset();
        for (int i = 0; i < 13; i++) step(1, 0);
        step(0, 0);
        for (int i = 0; i < 100; i++) step(1, 0);
        check("glitch_lost", 32'(lost_cnt), 32'd0);

        // Lock loss in RUN, then relock.
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("drop_rst", 32'(sys_rst_n), 32'd0);
        step(0, 0);
        check("drop_lost", 32'(lost_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0);
        for (int i = 0; i < 90; i++) step(1, 0);

        // Soft reset in RUN holds reset for HOLD_CYCLES.
        base = m_lost;
        step(1, 1);
        lowc = 0;
        for (int i = 0; i < 80; i++) begin
            if (sys_rst_n === 1'b0) lowc++;
            step(1, 0);
        end
        check("soft_low_len", 32'(lowc), 32'(H));
        check("soft_lost", 32'(lost_cnt), 32'(base));

        // Soft reset coincident with lock loss takes the LOST path.
        step(0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 0);
        check("coinc_lost", 32'(lost_cnt), 32'(base + 1));
        for (int i = 0; i < 90; i++) step(1, 0);

        // Soft reset during HOLD restarts the hold count.
        step(1, 1);
        for (int i = 0; i < 30; i++) step(1, 0);
        step(1, 1);
        for (int i = 0; i < 70; i++) step(1, 0);

        // Reset in HOLD aborts without counting a loss.
        do_reset();
        for (int i = 0; i < 40; i++) step(1, 0);
        do_reset();
        check("abort_lost", 32'(lost_cnt), 32'd0);

        // Saturation of the loss counter.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 22; i++) step(1, 0);
            for (int i = 0; i < 4; i++) step(0, 0);
        end
        check("lost_sat", 32'(lost_cnt), 32'd255);

        // Randomized run.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter FILT_CYCLES, default 16, meaning the number of consecutive cycles locked must stay stable before HOLD (legal range 1..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 64, meaning the number of cycles sys_rst_n is held low after the filter passes (legal range 1..65535).
REQ-003 SHALL have parameter CE_DIV, default 3, meaning the clock-enable divide ratio (legal range 1..256).
REQ-004 SHALL have port clk_sys, input, 1 bit: the single clock, one of the PLL outputs.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset for the block.
REQ-006 SHALL have port pll_locked, input, 1 bit: PLL lock indicator, asynchronous to clk_sys.
REQ-007 SHALL have port soft_rst, input, 1 bit: synchronous request to re-run the hold sequence.
REQ-008 SHALL have port sys_rst_n, output, 1 bit: registered active-low reset for downstream core logic.
REQ-009 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-010 SHALL have port lost_cnt, output, 8 bits: saturating count of lock-loss events.
REQ-011 SHALL have port ce, output, 1 bit: single-cycle clock-enable pulse.

Function
REQ-012 SHALL pass pll_locked through a 2-flop synchronizer; locked_s is the second flop, giving 2-cycle latency.
REQ-013 SHALL implement a state machine with states WAIT, FILT, HOLD, RUN and LOST, plus a 16-bit counter cnt.
REQ-014 In WAIT, locked_s=1 SHALL go to FILT with cnt=0.
REQ-015 In FILT, locked_s=0 SHALL go to WAIT; otherwise cnt==FILT_CYCLES-1 SHALL go to HOLD with cnt=0; otherwise cnt increments.
REQ-016 In HOLD, locked_s=0 SHALL go to LOST; otherwise soft_rst SHALL reset cnt to 0; otherwise cnt==HOLD_CYCLES-1 SHALL go to RUN; otherwise cnt increments.
REQ-017 In RUN, locked_s=0 SHALL go to LOST; otherwise soft_rst SHALL go to HOLD with cnt=0.
REQ-018 LOST SHALL last exactly one cycle, increment lost_cnt (saturating at 255, never wrapping), then go to WAIT.
REQ-019 When lock loss and soft_rst occur in the same cycle, lock loss SHALL take priority.
REQ-020 sys_rst_n and ready SHALL be registered from next-state: 1 exactly when the next state is RUN, 0 otherwise.
REQ-021 Timing SHALL be as follows: if edge k first samples pll_locked=1 and lock stays stable, sys_rst_n SHALL rise at edge k+2+FILT_CYCLES+HOLD_CYCLES.
REQ-022 The ce divider counter (0..CE_DIV-1) SHALL be held at 0 outside RUN and cleared on entering RUN.
REQ-023 In RUN, ce SHALL be 1 in the cycle the ce divider counter equals CE_DIV-1, and 0 otherwise.
REQ-024 CE_DIV=1 SHALL give ce=1 on every RUN cycle.
REQ-025 ce SHALL be 0 in every cycle in which ready=0.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=WAIT, cnt=0, both synchronizer flops=0, sys_rst_n=0, ready=0, lost_cnt=0, ce=0, ce divider counter=0.
REQ-027 rst_n deassertion SHALL take effect synchronously on the next clk_sys edge.
REQ-028 Reset mid-sequence (any state) SHALL abort the sequence, with no lost_cnt increment.

Configuration
REQ-029 With macro PLL_RESET_SEQ_CE_EN defined, the ce divider SHALL be compiled in per REQ-022..REQ-025.
REQ-030 With PLL_RESET_SEQ_CE_EN undefined, ce SHALL be tied to 0, no divider logic SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Defaults, rst_n released, pll_locked=1 sampled first at edge k -> sys_rst_n=1 and ready=1 at edge k+82; sys_rst_n=0 at all earlier edges.
REQ-032 pll_locked pulses low for 1 cycle during FILT at cnt=10 -> back to WAIT; a full 16-cycle filter restarts; lost_cnt stays 0.
REQ-033 In RUN, drop pll_locked -> 2 cycles later sys_rst_n=0 and ready=0, lost_cnt=1, state WAIT; relock -> RUN again after 82 cycles.
REQ-034 In RUN, soft_rst for 1 cycle -> sys_rst_n low for exactly 64 cycles, lost_cnt unchanged; soft_rst coincident with lock loss -> LOST path taken.
REQ-035 With CE_DIV=3 and PLL_RESET_SEQ_CE_EN defined -> first ce on the 3rd RUN cycle, then every 3rd cycle; with the macro undefined -> ce constantly 0.
REQ-036 300 forced lock-loss events -> lost_cnt saturates at 255.
